// File: rtl/car_alarm_pkg.sv
// ---------------------------------------------------------------------------
// car_alarm_pkg
// Shared definitions for the car-alarm sequencer: state codes, LED effect
// mode codes, countdown width and the state-to-LED-mode mapping.
// ---------------------------------------------------------------------------
package car_alarm_pkg;

  // Width of the tick countdown shown on the display (max 31 ticks).
  localparam int CNT_W = 5;

  // State codes are also the debug/display encoding on state_o.
  typedef enum logic [2:0] {
    ST_DISARMED = 3'd0,
    ST_EXIT     = 3'd1,
    ST_ARMED    = 3'd2,
    ST_ENTRY    = 3'd3,
    ST_ALARM    = 3'd4,
    ST_LOCKOUT  = 3'd5
  } state_t;

  // Mode codes understood by the LED effect block.
  localparam logic [1:0] LED_OFF    = 2'b00;
  localparam logic [1:0] LED_RUN    = 2'b01;
  localparam logic [1:0] LED_FLASH  = 2'b10;
  localparam logic [1:0] LED_EFFECT = 2'b11;

  // LED mode depends only on the state, so it stays constant for the whole
  // stay in a state and one-shot effects restart only on a real mode change.
  function automatic logic [1:0] led_for_state(input state_t st);
    case (st)
      ST_EXIT,
      ST_LOCKOUT: return LED_RUN;
      ST_ENTRY:   return LED_FLASH;
      ST_ALARM:   return LED_EFFECT;
      default:    return LED_OFF;
    endcase
  endfunction

endpackage

// File: rtl/car_alarm_ctrl_tick_gen.sv
// ---------------------------------------------------------------------------
// tick_gen
// Countdown prescaler: counts 0..TICK_DIV-1 and raises tick while the count
// sits at TICK_DIV-1. A clr pulse restarts the count so the first tick after
// a state change comes a full TICK_DIV cycles later.
// Ports:
//   clk   - system clock
//   reset - asynchronous, active-high reset
//   clr   - synchronous restart of the prescaler
//   tick  - one-cycle pulse every TICK_DIV cycles
// ---------------------------------------------------------------------------
module tick_gen #(
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] count;

  // Free-running modulo-TICK_DIV counter, restarted by clr.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr || (count == LAST)) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  // Not gated by clr: clr is derived from the state change that tick itself
  // can cause, so gating would form a combinational loop.
  assign tick = (count == LAST);

endmodule

// File: rtl/car_alarm_ctrl.sv
// ---------------------------------------------------------------------------
// car_alarm_ctrl
// Alarm sequencer: DISARMED -> EXIT -> ARMED -> ENTRY/ALARM -> LOCKOUT,
// driving the LED effect mode and the siren. All outputs are registered.
// Ports:
//   clk       - system clock
//   reset     - asynchronous, active-high reset
//   arm       - single-cycle arm request
//   disarm    - single-cycle disarm request
//   door      - level, 1 = door open
//   shock     - level, 1 = shock sensor active
//   led_mode  - LED effect mode (off / run / flash / effect)
//   siren     - siren enable
//   state_o   - current state code
//   countdown - ticks remaining in EXIT/ENTRY/ALARM, else 0
//   lockout   - high in LOCKOUT
// ---------------------------------------------------------------------------
module car_alarm_ctrl
  import car_alarm_pkg::*;
#(
  parameter int unsigned TICK_DIV    = 50000000,
  parameter int unsigned EXIT_TICKS  = 10,
  parameter int unsigned ENTRY_TICKS = 8,
  parameter int unsigned ALARM_TICKS = 30,
  parameter int unsigned MAX_ALARMS  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             arm,
  input  logic             disarm,
  input  logic             door,
  input  logic             shock,
  output logic [1:0]       led_mode,
  output logic             siren,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] countdown,
  output logic             lockout
);

  state_t           state;
  state_t           next_state;
  logic [2:0]       alarm_cnt;
  logic [2:0]       alarm_cnt_next;
  logic [CNT_W-1:0] cd_next;
  logic             tick;
  logic             expiry;
  logic             state_change;

  assign expiry       = tick && (countdown == CNT_W'(1));
  assign state_change = (next_state != state);

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .clr   (state_change),
    .tick  (tick)
  );

  // Next state. Disarm outranks everything and is the only input LOCKOUT
  // listens to; unused codes fall back to DISARMED.
  always_comb begin
    next_state = state;
    if (disarm) begin
      next_state = ST_DISARMED;
    end else begin
      case (state)
        ST_DISARMED: if (arm && !door) next_state = ST_EXIT;
        ST_EXIT:     if (expiry) next_state = ST_ARMED;
        ST_ARMED: begin
          if (shock)     next_state = ST_ALARM;
          else if (door) next_state = ST_ENTRY;
        end
        ST_ENTRY:    if (shock || expiry) next_state = ST_ALARM;
        ST_ALARM: begin
          if (expiry) begin
            next_state = (alarm_cnt < 3'(MAX_ALARMS)) ? ST_ARMED : ST_LOCKOUT;
          end
        end
        ST_LOCKOUT:  next_state = ST_LOCKOUT;
        default:     next_state = ST_DISARMED;
      endcase
    end
  end

  // Countdown reloads on entry to a timed state and steps down per tick;
  // untimed states always land on 0. Alarm episodes are counted on ALARM
  // entry and forgotten whenever the system goes back to DISARMED.
  always_comb begin
    cd_next        = countdown;
    alarm_cnt_next = alarm_cnt;
    if (state_change) begin
      case (next_state)
        ST_EXIT:  cd_next = CNT_W'(EXIT_TICKS);
        ST_ENTRY: cd_next = CNT_W'(ENTRY_TICKS);
        ST_ALARM: cd_next = CNT_W'(ALARM_TICKS);
        default:  cd_next = '0;
      endcase
    end else if (tick && (countdown != '0)) begin
      cd_next = countdown - 1'b1;
    end

    if (next_state == ST_DISARMED) begin
      alarm_cnt_next = '0;
    end else if (state_change && (next_state == ST_ALARM) && (alarm_cnt != 3'd7)) begin
      alarm_cnt_next = alarm_cnt + 1'b1;
    end
  end

  // Outputs are derived from next_state so they change on the same edge as
  // the state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_DISARMED;
      countdown <= '0;
      alarm_cnt <= '0;
      led_mode  <= LED_OFF;
      siren     <= 1'b0;
      lockout   <= 1'b0;
    end else begin
      state     <= next_state;
      countdown <= cd_next;
      alarm_cnt <= alarm_cnt_next;
      led_mode  <= led_for_state(next_state);
      siren     <= (next_state == ST_ALARM);
      lockout   <= (next_state == ST_LOCKOUT);
    end
  end

  assign state_o = state;

endmodule
